// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared constants and types for the RegisterFile writeback path.
//   XLEN       : data width of one architectural register
//   REG_ADDR_W : width of a register index
//   NUM_REGS   : architectural register count; register 0 reads as zero
package regfile_pkg;
  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]       xlen_t;

  localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Round-robin arbiter with an internal rotating pointer. The grant is
//   purely combinational from req_i and the registered pointer; the pointer
//   moves to one past the winner whenever something is granted.
//   Ports:
//     clk_i   : clock
//     rst_i   : asynchronous active-high reset
//     req_i   : N-wide request vector
//     grant_o : one-hot grant (all zero when nothing requests)
//   Build option RFWB_FIXED_PRIO_EN: requester 0 always wins when it
//   requests; requesters 1..N-1 rotate among themselves and the pointer
//   never lands on 0.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] grant_o
);
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

`ifdef RFWB_FIXED_PRIO_EN
  localparam logic [PTR_W-1:0] RST_PTR = PTR_W'(1);
`else
  localparam logic [PTR_W-1:0] RST_PTR = '0;
`endif

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
`ifdef RFWB_FIXED_PRIO_EN
    if (req_i[0]) begin
      grant_o[0] = 1'b1;
      found      = 1'b1;
    end
    // Rotation over 1..N-1 only; wrap subtracts N-1 so 0 is skipped.
    for (int k = 0; k < N - 1; k++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(N)) sum = sum - (PTR_W+1)'(N - 1);
      idx = sum[PTR_W-1:0];
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
        ptr_d        = (idx == PTR_W'(N - 1)) ? PTR_W'(1) : idx + PTR_W'(1);
      end
    end
`else
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(N)) sum = sum - (PTR_W+1)'(N);
      idx = sum[PTR_W-1:0];
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
        ptr_d        = (idx == PTR_W'(N - 1)) ? '0 : idx + PTR_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= RST_PTR;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Owns the single RegisterFile write port. Arbitrates NUM_REQ writeback
//   requesters round-robin, registers the winning write (1-cycle latency)
//   and keeps a pending-write scoreboard that stalls issue on RAW/WAW.
//   Ports:
//     clk_i, rst_i                  : clock, async active-high reset
//     wb_valid_i/wb_rd_i/wb_data_i  : per-requester writeback (slice i)
//     wb_ready_o                    : one-hot grant
//     rf_we_o/rf_rd_o/rf_wdata_o    : registered RegisterFile write
//     issue_valid_i, issue_rd_i,
//     issue_rs1_i, issue_rs2_i      : instruction issuing this cycle
//     issue_stall_o                 : hazard flag from registered busy bits
//     flush_i                       : clears the scoreboard
//   Build option RFWB_FIXED_PRIO_EN (in rr_arbiter): requester 0 has fixed
//   top priority.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            wb_valid_i,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] wb_rd_i,
  input  logic [NUM_REQ*XLEN-1:0]       wb_data_i,
  output logic [NUM_REQ-1:0]            wb_ready_o,
  output logic                          rf_we_o,
  output reg_idx_t                      rf_rd_o,
  output xlen_t                         rf_wdata_o,
  input  logic                          issue_valid_i,
  input  reg_idx_t                      issue_rd_i,
  input  reg_idx_t                      issue_rs1_i,
  input  reg_idx_t                      issue_rs2_i,
  output logic                          issue_stall_o,
  input  logic                          flush_i
);
  logic [NUM_REQ-1:0]  grant;
  logic                hs;
  reg_idx_t            gnt_rd;
  xlen_t               gnt_data;
  logic                wr_d;
  logic                rf_we_q;
  reg_idx_t            rf_rd_q;
  xlen_t               rf_wdata_q;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (wb_valid_i),
    .grant_o (grant)
  );

  // Grant only goes to a valid requester, so any ready bit is a handshake.
  assign wb_ready_o = rst_i ? '0 : grant;
  assign hs         = |wb_ready_o;

  always_comb begin
    gnt_rd   = REG_ZERO;
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gnt_rd   = gnt_rd   | wb_rd_i[i*REG_ADDR_W +: REG_ADDR_W];
        gnt_data = gnt_data | wb_data_i[i*XLEN +: XLEN];
      end
    end
  end

  // Writes to x0 are accepted from the requester but never reach the file.
  assign wr_d = hs && (gnt_rd != REG_ZERO);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= REG_ZERO;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= wr_d;
      if (wr_d) begin
        rf_rd_q    <= gnt_rd;
        rf_wdata_q <= gnt_data;
      end
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_rd_o    = rf_rd_q;
  assign rf_wdata_o = rf_wdata_q;

  assign issue_stall_o = busy_q[issue_rs1_i] | busy_q[issue_rs2_i] | busy_q[issue_rd_i];

  // Clear is applied first so a same-index set in the same cycle wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) busy_d[rf_rd_q] = 1'b0;
    if (flush_i) begin
      busy_d = '0;
    end else if (issue_valid_i && !issue_stall_o && (issue_rd_i != REG_ZERO)) begin
      busy_d[issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 64-bit, 32-entry RegisterFile (one write port, two synchronous read ports).
- Arbitrates writeback requests from NUM_REQ execution units (ALU, load, CSR, ...) using round-robin.
- Drives a registered write onto the RegisterFile.
- Keeps a pending-write scoreboard that stalls issue on RAW/WAW hazards.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8)
- XLEN, 64, data width
- NUM_REGS, 32, architectural registers; register 0 is hardwired zero

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- wb_valid  in  NUM_REQ  per-requester write request
- wb_rd  in  NUM_REQ*5  per-requester destination index, slice i = requester i
- wb_data  in  NUM_REQ*XLEN  per-requester write data
- wb_ready  out  NUM_REQ  one-hot grant; transfer when wb_valid[i] & wb_ready[i]
- rf_we  out  1  to RegisterFile we
- rf_rd  out  5  to RegisterFile rd
- rf_wdata  out  XLEN  to RegisterFile write_data
- issue_valid  in  1  an instruction issues this cycle
- issue_rd  in  5  its destination (0 = no writeback)
- issue_rs1  in  5  source 1 index
- issue_rs2  in  5  source 2 index
- issue_stall  out  1  combinational hazard flag; issue_valid is ignored while high
- flush  in  1  pipeline flush, clears scoreboard

Behaviour:
- Reset (async, rst high): rf_we=0, rf_rd=0, rf_wdata=0, busy[]=0, rr pointer=0. wb_ready=0 while rst is high.
- Grant (combinational):
  - Search wb_valid starting at pointer, wrapping modulo NUM_REQ; the first valid requester gets wb_ready.
  - At most one wb_ready bit is high per cycle.
  - No valid request: wb_ready=0.
  - wb_ready never depends on stall or flush.
- Pointer: after a grant to i, pointer <= (i+1) mod NUM_REQ. No grant: pointer unchanged.
- Write stage, registered, 1-cycle latency:
  - Handshake in cycle T gives rf_we=1 in T+1, with rf_rd and rf_wdata from the granted slice.
  - No handshake in T gives rf_we=0 in T+1; rf_rd and rf_wdata hold their previous values.
  - Handshake with wb_rd=0 is accepted, but rf_we stays 0 and the write is dropped.
- Scoreboard busy[1..NUM_REGS-1], busy[0] constant 0:
  - Set: issue_valid & ~issue_stall & issue_rd!=0 sets busy[issue_rd].
  - Clear: rf_we=1 clears busy[rf_rd] at the edge ending that cycle.
  - This timing lets a read issued at T+2 see the written value, since the RegisterFile read is registered.
  - Set and clear of the same index in one cycle: set wins.
- issue_stall = busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd], combinational from registered busy only (no same-cycle forwarding).
- Flush: clears all busy bits on the next edge. A flush with a simultaneous issue_valid drops the set. The in-flight rf_we write still completes; handshakes in the flush cycle are still accepted and written.
- Reset mid-write: the in-flight write is lost and rf_we is forced to 0 immediately.

Optional Feature:
- Macro RFWB_FIXED_PRIO_EN.
- Defined: requester 0 (load unit) always wins whenever wb_valid[0]=1. The remaining requesters use round-robin among themselves, and the pointer skips 0.
- Undefined: pure round-robin across all NUM_REQ requesters.

Decomposition:
- Shared package regfile_pkg holds:
  - XLEN=64, REG_ADDR_W=5, NUM_REGS=32
  - typedef reg_idx_t (5-bit) and xlen_t (64-bit)
  - constant REG_ZERO=0
- One sub-module, rr_arbiter (NUM_REQ-wide request vector, pointer, one-hot grant). It contains the RFWB_FIXED_PRIO_EN variant.
- Scoreboard and write stage stay in the top module.

Test Plan:
- Single write: req1 valid, rd=5, data=0xDEAD_BEEF at T -> wb_ready[1]=1 at T; at T+1 rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF; at T+2 rf_we=0.
- Round-robin: all three requesters valid continuously from reset -> grants 0,1,2,0,1,2, one per cycle. With RFWB_FIXED_PRIO_EN defined -> 0,0,0 while wb_valid[0] stays high.
- Hazard:
  - Issue rd=7 at T -> issue_stall=1 for rs1=7 from T+1.
  - Writeback rd=7 handshake at T+3 -> rf_we at T+4 -> stall drops at T+5.
- x0 write: handshake with wb_rd=0, data=0xFFFF -> rf_we stays 0; issue with rd=0 never sets busy or stall.
- Set/clear collision: rf_we with rf_rd=9 in the same cycle as an issue with rd=9 -> busy[9]=1 afterward.
- Flush and reset:
  - Busy {3,4} set, flush pulse -> busy all 0 next cycle; the in-flight rf_we still asserts.
  - rst asserted mid-write -> rf_we=0 immediately, without waiting for a clk edge.
